store_narrow_unit: RTL and testbench
====================================

// Module: store_narrow_unit
// PURPOSE
//   Store-path counterpart of the immediate/load sign extender: narrows a 32-bit register value
//   to byte/half/word, steers it onto little-endian byte lanes with byte enables, and performs
//   the data-memory write via a req/ack handshake. Sits between MEM-stage control and data memory.
//   Detects misaligned/illegal stores and bus timeouts.
// PARAMETERS
//   DATA_WIDTH   32   register/memory data width (fixed 32; 4 byte lanes)
//   ADDR_WIDTH   32   byte address width
//   ACK_TIMEOUT  15   max cycles MemWE waits for MemAck before BusErr (>=1)
// PORTS
//   CLK          in   1              rising-edge clock
//   RST          in   1              asynchronous, active-low reset
//   StoreReq     in   1              store request; sampled only when Ready=1
//   StoreSize    in   2              00 byte, 01 half, 10 word, 11 reserved
//   Addr         in   ADDR_WIDTH     byte address of store
//   WriteData    in   DATA_WIDTH     register value; low bits used for byte/half
//   Ready        out  1              1 = IDLE, request accepted this cycle
//   MemAddr      out  ADDR_WIDTH     word-aligned address {Addr[31:2],2'b00}
//   MemWData     out  DATA_WIDTH     lane-replicated write data
//   MemBE        out  4              byte enables, bit k = lane [8k+7:8k]
//   MemWE        out  1              write strobe, held until MemAck or timeout
//   MemAck       in   1              memory accepted write (valid only while MemWE=1)
//   Done         out  1              1-cycle pulse: write completed
//   MisalignExc  out  1              1-cycle pulse: misaligned/illegal store, no write issued
//   BusErr       out  1              1-cycle pulse: ACK_TIMEOUT expired
//   BadAddr      out  ADDR_WIDTH     address of last faulting store (held until next fault)
// BEHAVIOUR
//   Reset (RST=0, async): state IDLE; Ready=1; MemWE=0, MemBE=0, MemAddr=0, MemWData=0;
//     Done=MisalignExc=BusErr=0; BadAddr=0; timeout counter=0. Reset mid-write aborts silently.
//   FSM: IDLE -> WRITE on accepted aligned StoreReq; IDLE -> FAULT on accepted misaligned/illegal;
//     WRITE -> DONE on MemAck=1; WRITE -> FAULT(BusErr) when counter reaches ACK_TIMEOUT;
//     DONE -> IDLE, FAULT -> IDLE unconditionally (one cycle each).
//   Latency: request at edge N -> MemWE=1 from N+1; MemAck sampled at edge M -> Done=1 in M+1 cycle;
//     Ready returns in cycle after Done. Min store occupancy 3 cycles (ack in first WRITE cycle).
//   All memory outputs registered at accept and stable throughout WRITE; MemBE=0 outside WRITE.
//   Alignment: byte always legal; half illegal if Addr[0]=1; word illegal if Addr[1:0]!=0;
//     StoreSize=11 always illegal. Illegal -> MisalignExc pulse in FAULT cycle, BadAddr=Addr, no MemWE.
//   Lane steering (k=Addr[1:0]): byte -> MemWData={4{WriteData[7:0]}}, MemBE=1<<k;
//     half -> MemWData={2{WriteData[15:0]}}, MemBE=k[1]?4'b1100:4'b0011; word -> WriteData, 4'b1111.
//     Upper unused bits of WriteData are discarded (truncation, no sign check).
//   Timeout: counter clears on entry to WRITE, increments each WRITE cycle without ack; MemAck on
//     the same edge the counter hits ACK_TIMEOUT wins (Done, not BusErr). BusErr sets BadAddr=MemAddr|k.
//   StoreReq while Ready=0 is ignored (caller must hold). MemAck outside WRITE is ignored.
// STRUCTURE
//   mips_pkg: StoreSize encodings (SZ_BYTE/SZ_HALF/SZ_WORD), state enum (IDLE/WRITE/DONE/FAULT).
//   Sub-module store_lane_align: combinational {StoreSize,Addr[1:0],WriteData} -> {WData,BE,Misalign}.
//   Top holds FSM, output registers, timeout counter, BadAddr register.
// TESTING
//   Byte store Addr=0x1003, WriteData=0xDEADBEEF, ack 1st cycle -> MemAddr=0x1000, MemWData=0xEFEFEFEF,
//     MemBE=1000, Done 3rd cycle after request.
//   Half store Addr=0x2002, WriteData=0x1234ABCD, ack after 4 cycles -> MemWData=0xABCDABCD, BE=1100,
//     MemWE high exactly 5 cycles, one Done pulse.
//   Word store Addr=0x3001 -> MisalignExc pulse, BadAddr=0x3001, MemWE never 1; StoreSize=11 same.
//   Word store Addr=0x4000, no ack, ACK_TIMEOUT=15 -> BusErr after 16 WRITE cycles, BadAddr=0x4000,
//     Ready returns; ack on final cycle instead -> Done, no BusErr.
//   RST low during WRITE -> all outputs to reset values immediately; next store completes normally.
//   Back-to-back requests held high -> second accepted only on Ready, outputs unchanged mid-WRITE.

Source files
------------

// File: rtl/store_narrow_unit_pkg.sv
// Shared widths, store-size encodings, FSM state codes and the lane-steering payload
// for the store narrowing unit.
package store_narrow_unit_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LANES  = DATA_W / 8;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
  localparam logic [1:0] ST_FAULT = 2'd3;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [LANES-1:0]  be;
    logic              misalign;
  } lane_t;

endpackage

// File: rtl/store_narrow_unit_if.sv
// Store request / data-memory write bundle. The unit uses the slave view, its
// requester and the memory model use the master view.
interface store_narrow_unit_if;
  import store_narrow_unit_pkg::*;

  logic              store_req;
  logic [1:0]        store_size;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [LANES-1:0]  mem_be;
  logic              mem_we;
  logic              mem_ack;
  logic              done;
  logic              misalign_exc;
  logic              bus_err;
  logic [ADDR_W-1:0] bad_addr;

  modport slave (
    input  store_req, store_size, addr, wdata, mem_ack,
    output ready, mem_addr, mem_wdata, mem_be, mem_we,
           done, misalign_exc, bus_err, bad_addr
  );

  modport master (
    output store_req, store_size, addr, wdata, mem_ack,
    input  ready, mem_addr, mem_wdata, mem_be, mem_we,
           done, misalign_exc, bus_err, bad_addr
  );
endinterface

// File: rtl/store_narrow_unit_lane_align.sv
// Combinational narrowing: replicates the store value across little-endian byte
// lanes, builds byte enables and flags misaligned or reserved-size stores.
module store_narrow_unit_lane_align
  import store_narrow_unit_pkg::*;
(
  input  logic [1:0]        size_i,
  input  logic [1:0]        offset_i,
  input  logic [DATA_W-1:0] wdata_i,
  output lane_t             lane_o
);

  always_comb begin
    lane_o = '0;
    case (size_i)
      SZ_BYTE: begin
        lane_o.data = {4{wdata_i[7:0]}};
        lane_o.be   = 4'b0001 << offset_i;
      end
      SZ_HALF: begin
        lane_o.data     = {2{wdata_i[15:0]}};
        lane_o.be       = offset_i[1] ? 4'b1100 : 4'b0011;
        lane_o.misalign = offset_i[0];
      end
      SZ_WORD: begin
        lane_o.data     = wdata_i;
        lane_o.be       = 4'b1111;
        lane_o.misalign = (offset_i != 2'b00);
      end
      default: lane_o.misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/store_narrow_unit.sv
// MEM-stage store unit: accepts a store, issues a registered byte-enabled memory
// write with a req/ack handshake, and reports completion, misalignment or ack timeout.
module store_narrow_unit
  import store_narrow_unit_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  store_narrow_unit_if.slave bus
);

  localparam int unsigned CNT_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);

  lane_t lane;

  logic [1:0]        state_q,     state_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;
  logic [1:0]        offset_q,    offset_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [LANES-1:0]  mem_be_q,    mem_be_d;
  logic              mem_we_q,    mem_we_d;
  logic              ready_q,     ready_d;
  logic              done_q,      done_d;
  logic              mis_q,       mis_d;
  logic              berr_q,      berr_d;
  logic [ADDR_W-1:0] bad_addr_q,  bad_addr_d;

  store_narrow_unit_lane_align u_lane_align (
    .size_i   (bus.store_size),
    .offset_i (bus.addr[1:0]),
    .wdata_i  (bus.wdata),
    .lane_o   (lane)
  );

  // Next-state and next-output logic; pulses default low, bus payload holds.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    offset_d    = offset_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    mem_we_d    = mem_we_q;
    bad_addr_d  = bad_addr_q;
    done_d      = 1'b0;
    mis_d       = 1'b0;
    berr_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.store_req) begin
          offset_d = bus.addr[1:0];
          if (lane.misalign) begin
            state_d    = ST_FAULT;
            mis_d      = 1'b1;
            bad_addr_d = bus.addr;
          end else begin
            state_d     = ST_WRITE;
            cnt_d       = '0;
            mem_addr_d  = {bus.addr[ADDR_W-1:2], 2'b00};
            mem_wdata_d = lane.data;
            mem_be_d    = lane.be;
            mem_we_d    = 1'b1;
          end
        end
      end
      ST_WRITE: begin
        // Ack takes priority over a timeout landing on the same edge.
        if (bus.mem_ack) begin
          state_d  = ST_DONE;
          done_d   = 1'b1;
          mem_we_d = 1'b0;
          mem_be_d = '0;
        end else if (cnt_q == CNT_W'(ACK_TIMEOUT)) begin
          state_d    = ST_FAULT;
          berr_d     = 1'b1;
          bad_addr_d = mem_addr_q | ADDR_W'(offset_q);
          mem_we_d   = 1'b0;
          mem_be_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      offset_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      mem_we_q    <= 1'b0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      mis_q       <= 1'b0;
      berr_q      <= 1'b0;
      bad_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      offset_q    <= offset_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      mem_we_q    <= mem_we_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      mis_q       <= mis_d;
      berr_q      <= berr_d;
      bad_addr_q  <= bad_addr_d;
    end
  end

  assign bus.ready        = ready_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_wdata    = mem_wdata_q;
  assign bus.mem_be       = mem_be_q;
  assign bus.mem_we       = mem_we_q;
  assign bus.done         = done_q;
  assign bus.misalign_exc = mis_q;
  assign bus.bus_err      = berr_q;
  assign bus.bad_addr     = bad_addr_q;

endmodule

// File: tb/tb_store_narrow_unit.sv
// Directed bench for store_narrow_unit: lane steering, alignment faults, ack timeout,
// mid-write reset and back-to-back requests, against hand-computed expectations.
module tb_store_narrow_unit;
  import store_narrow_unit_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  store_narrow_unit_if bus ();

  store_narrow_unit #(.ACK_TIMEOUT(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    bus.store_req  = 1'b1;
    bus.store_size = sz;
    bus.addr       = a;
    bus.wdata      = d;
    tick();
    bus.store_req  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", bus.ready); end
    checks++; if (bus.mem_we !== 1'b0 || bus.mem_be !== 4'h0) begin errors++; $display("FAIL reset_we_be got %b/%h exp 0/0", bus.mem_we, bus.mem_be); end
    checks++; if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_addr_data got %h/%h exp 0/0", bus.mem_addr, bus.mem_wdata); end
    checks++; if ({bus.done, bus.misalign_exc, bus.bus_err} !== 3'b000 || bus.bad_addr !== 32'h0) begin errors++; $display("FAIL reset_flags got %b bad %h exp 000/0", {bus.done, bus.misalign_exc, bus.bus_err}, bus.bad_addr); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_byte();
    issue(SZ_BYTE, 32'h0000_1003, 32'hDEAD_BEEF);
    checks++; if (bus.mem_we !== 1'b1 || bus.ready !== 1'b0) begin errors++; $display("FAIL byte_we got we %b rdy %b exp 1/0", bus.mem_we, bus.ready); end
    checks++; if (bus.mem_addr !== 32'h0000_1000) begin errors++; $display("FAIL byte_addr got %h exp 00001000", bus.mem_addr); end
    checks++; if (bus.mem_wdata !== 32'hEFEF_EFEF || bus.mem_be !== 4'b1000) begin errors++; $display("FAIL byte_lanes got %h/%b exp efefefef/1000", bus.mem_wdata, bus.mem_be); end
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    checks++; if (bus.done !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_be !== 4'h0) begin errors++; $display("FAIL byte_done got done %b we %b be %b exp 1/0/0", bus.done, bus.mem_we, bus.mem_be); end
    tick();
    checks++; if (bus.ready !== 1'b1 || bus.done !== 1'b0) begin errors++; $display("FAIL byte_ready got rdy %b done %b exp 1/0", bus.ready, bus.done); end
  endtask

  task automatic test_half();
    int we_cnt;
    int done_cnt;
    logic lanes_ok;
    we_cnt = 0; done_cnt = 0; lanes_ok = 1'b1;
    issue(SZ_HALF, 32'h0000_2002, 32'h1234_ABCD);
    for (int c = 0; c < 10; c++) begin
      if (bus.mem_we) begin
        we_cnt++;
        if (bus.mem_wdata !== 32'hABCD_ABCD || bus.mem_be !== 4'b1100) lanes_ok = 1'b0;
      end
      if (bus.done) done_cnt++;
      bus.mem_ack = (c == 4);
      tick();
    end
    bus.mem_ack = 1'b0;
    checks++; if (we_cnt !== 5) begin errors++; $display("FAIL half_we_cycles got %0d exp 5", we_cnt); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL half_done_pulses got %0d exp 1", done_cnt); end
    checks++; if (lanes_ok !== 1'b1) begin errors++; $display("FAIL half_lanes got bad lanes exp abcdabcd/1100"); end
  endtask

  task automatic test_misalign();
    issue(SZ_WORD, 32'h0000_3001, 32'h0);
    checks++; if (bus.misalign_exc !== 1'b1 || bus.mem_we !== 1'b0) begin errors++; $display("FAIL mis_word got exc %b we %b exp 1/0", bus.misalign_exc, bus.mem_we); end
    checks++; if (bus.bad_addr !== 32'h0000_3001) begin errors++; $display("FAIL mis_word_bad got %h exp 00003001", bus.bad_addr); end
    tick();
    checks++; if (bus.misalign_exc !== 1'b0 || bus.ready !== 1'b1 || bus.bad_addr !== 32'h0000_3001) begin errors++; $display("FAIL mis_word_after got exc %b rdy %b bad %h exp 0/1/00003001", bus.misalign_exc, bus.ready, bus.bad_addr); end
    issue(SZ_RSVD, 32'h0000_3100, 32'h0);
    checks++; if (bus.misalign_exc !== 1'b1 || bus.mem_we !== 1'b0 || bus.bad_addr !== 32'h0000_3100) begin errors++; $display("FAIL mis_rsvd got exc %b we %b bad %h exp 1/0/00003100", bus.misalign_exc, bus.mem_we, bus.bad_addr); end
    tick();
    issue(SZ_HALF, 32'h0000_5001, 32'h0);
    checks++; if (bus.misalign_exc !== 1'b1 || bus.bad_addr !== 32'h0000_5001) begin errors++; $display("FAIL mis_half got exc %b bad %h exp 1/00005001", bus.misalign_exc, bus.bad_addr); end
    tick();
  endtask

  task automatic run_timeout(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] exp_bad);
    int n;
    n = 0;
    issue(sz, a, 32'h55AA_55AA);
    for (int c = 0; c < 40; c++) begin
      if (bus.bus_err) break;
      if (bus.mem_we) n++;
      tick();
    end
    checks++; if (bus.bus_err !== 1'b1 || n !== 16) begin errors++; $display("FAIL timeout_%h got berr %b we_cycles %0d exp 1/16", a, bus.bus_err, n); end
    checks++; if (bus.bad_addr !== exp_bad || bus.mem_we !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL timeout_bad_%h got %h we %b done %b exp %h/0/0", a, bus.bad_addr, bus.mem_we, bus.done, exp_bad); end
    tick();
    checks++; if (bus.ready !== 1'b1 || bus.bus_err !== 1'b0) begin errors++; $display("FAIL timeout_ready_%h got rdy %b berr %b exp 1/0", a, bus.ready, bus.bus_err); end
  endtask

  task automatic test_timeout();
    run_timeout(SZ_WORD, 32'h0000_4000, 32'h0000_4000);
    run_timeout(SZ_BYTE, 32'h0000_4403, 32'h0000_4403);
  endtask

  task automatic test_ack_last();
    issue(SZ_WORD, 32'h0000_4800, 32'h0102_0304);
    for (int c = 0; c < 15; c++) tick();
    checks++; if (bus.mem_we !== 1'b1) begin errors++; $display("FAIL ack_last_we got %b exp 1", bus.mem_we); end
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    checks++; if (bus.done !== 1'b1 || bus.bus_err !== 1'b0) begin errors++; $display("FAIL ack_last got done %b berr %b exp 1/0", bus.done, bus.bus_err); end
    tick();
  endtask

  task automatic test_reset_mid_write();
    issue(SZ_WORD, 32'h0000_6000, 32'h1111_2222);
    tick();
    checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h0000_6000) begin errors++; $display("FAIL rst_mid_pre got we %b addr %h exp 1/00006000", bus.mem_we, bus.mem_addr); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.mem_we !== 1'b0 || bus.mem_be !== 4'h0 || bus.ready !== 1'b1) begin errors++; $display("FAIL rst_mid got we %b be %b rdy %b exp 0/0/1", bus.mem_we, bus.mem_be, bus.ready); end
    checks++; if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0 || bus.bad_addr !== 32'h0) begin errors++; $display("FAIL rst_mid_regs got %h/%h/%h exp 0/0/0", bus.mem_addr, bus.mem_wdata, bus.bad_addr); end
    tick();
    rst_n = 1'b1;
    tick();
    issue(SZ_BYTE, 32'h0000_7001, 32'h0000_00A5);
    checks++; if (bus.mem_wdata !== 32'hA5A5_A5A5 || bus.mem_be !== 4'b0010 || bus.mem_addr !== 32'h0000_7000) begin errors++; $display("FAIL rst_after got %h/%b/%h exp a5a5a5a5/0010/00007000", bus.mem_wdata, bus.mem_be, bus.mem_addr); end
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL rst_after_done got %b exp 1", bus.done); end
    tick();
  endtask

  task automatic test_back_to_back();
    bus.store_req  = 1'b1;
    bus.store_size = SZ_WORD;
    bus.addr       = 32'h0000_8000;
    bus.wdata      = 32'hCAFE_F00D;
    tick();
    bus.addr  = 32'h0000_8004;
    bus.wdata = 32'h0BAD_BEEF;
    tick(); tick();
    checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h0000_8000 || bus.mem_wdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL b2b_hold got we %b %h/%h exp 1/00008000/cafef00d", bus.mem_we, bus.mem_addr, bus.mem_wdata); end
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    checks++; if (bus.done !== 1'b1 || bus.ready !== 1'b0) begin errors++; $display("FAIL b2b_done got done %b rdy %b exp 1/0", bus.done, bus.ready); end
    tick();
    checks++; if (bus.ready !== 1'b1 || bus.mem_we !== 1'b0) begin errors++; $display("FAIL b2b_idle got rdy %b we %b exp 1/0", bus.ready, bus.mem_we); end
    tick();
    bus.store_req = 1'b0;
    checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h0000_8004 || bus.mem_wdata !== 32'h0BAD_BEEF) begin errors++; $display("FAIL b2b_second got we %b %h/%h exp 1/00008004/0badbeef", bus.mem_we, bus.mem_addr, bus.mem_wdata); end
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL b2b_second_done got %b exp 1", bus.done); end
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.store_req  = 1'b0;
    bus.store_size = SZ_BYTE;
    bus.addr       = '0;
    bus.wdata      = '0;
    bus.mem_ack    = 1'b0;
    test_reset();
    test_byte();
    test_half();
    test_misalign();
    test_timeout();
    test_ack_last();
    test_reset_mid_write();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
